// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the instruction-memory boot loader.
// Holds the loader FSM states, the byte-lane count and the word-counter width rule.
package loader_pkg;

  typedef enum logic [1:0] {
    LEN   = 2'd0,
    DATA  = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } state_e;

  localparam int LANES = 4;

  // One extra bit so a count equal to the full memory depth is representable.
  function automatic int wordCountWidth(input int addrWidth);
    return addrWidth + 1;
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a byte stream into little-endian 32-bit words; the first byte lands in [7:0].
// word_valid_o is asserted combinationally while the lane-3 byte is being accepted.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid_i,
  input  logic [7:0]  in_data_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [1:0]  lane_q;
  logic [1:0]  lane_d;
  logic [23:0] partial_q;
  logic [23:0] partial_d;

  always_comb begin
    lane_d    = lane_q;
    partial_d = partial_q;
    if (in_valid_i) begin
      lane_d = lane_q + 2'd1;
      case (lane_q)
        2'd0:    partial_d[7:0]   = in_data_i;
        2'd1:    partial_d[15:8]  = in_data_i;
        2'd2:    partial_d[23:16] = in_data_i;
        default: partial_d        = partial_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q    <= 2'd0;
      partial_q <= 24'd0;
    end else begin
      lane_q    <= lane_d;
      partial_q <= partial_d;
    end
  end

  assign word_o       = {in_data_i, partial_q};
  assign word_valid_o = in_valid_i && (lane_q == 2'(LANES - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: reads a length header and payload from the host link, writes
// the words to instruction memory and releases the CPU reset once the image is in.
module imem_loader
  import loader_pkg::*;
#(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_rst_n,
  output logic        done,
  output logic        error
);

  localparam int          CW    = wordCountWidth(ADDR_WIDTH);
  localparam logic [32:0] DEPTH = 33'd1 << ADDR_WIDTH;

  state_e          state_q, state_d;
  logic [CW-1:0]   word_idx_q, word_idx_d;
  logic [CW-1:0]   nwords_q, nwords_d;
  logic            mem_we_q, mem_we_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic            cpu_rst_n_q, cpu_rst_n_d;
  logic            done_q, done_d;
  logic            error_q, error_d;

  logic            accept;
  logic [31:0]     word;
  logic            word_valid;
  logic [CW-1:0]   idx_next;

  // Ready comes only from registered state so it never loops back through rx_valid.
  assign rx_ready = (state_q == LEN) || (state_q == DATA);
  assign accept   = rx_valid && rx_ready;
  assign idx_next = word_idx_q + CW'(1);

  byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_i   (accept),
    .in_data_i    (rx_data),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  always_comb begin
    state_d     = state_q;
    word_idx_d  = word_idx_q;
    nwords_d    = nwords_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rst_n_d = cpu_rst_n_q;
    done_d      = done_q;
    error_d     = error_q;
    case (state_q)
      LEN: begin
        if (word_valid) begin
          if (word == 32'd0) begin
            state_d     = DONE;
            done_d      = 1'b1;
            cpu_rst_n_d = 1'b1;
          end else if ({1'b0, word} > DEPTH) begin
            state_d = ERROR;
            error_d = 1'b1;
          end else begin
            state_d  = DATA;
            nwords_d = word[CW-1:0];
          end
        end
      end
      DATA: begin
        if (word_valid) begin
          mem_we_d    = 1'b1;
          mem_wdata_d = word;
          mem_addr_d  = BASE_ADDR + 32'({word_idx_q, 2'b00});
          word_idx_d  = idx_next;
          if (idx_next == nwords_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      // Releasing one cycle into DONE lands the release just after the last write strobe.
      DONE: cpu_rst_n_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LEN;
      word_idx_q  <= '0;
      nwords_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      mem_wdata_q <= 32'd0;
      cpu_rst_n_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_idx_q  <= word_idx_d;
      nwords_q    <= nwords_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rst_n = cpu_rst_n_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven image loads plus hand-written
// sequences for reset values and reset in the middle of a load.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;

  logic        readyA, weA, cpuA, doneA, errA;
  logic [31:0] addrA, wdataA;
  logic        readyB, weB, cpuB, doneB, errB;
  logic [31:0] addrB, wdataB;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  logic [31:0] wrAddrA[$];
  logic [31:0] wrDataA[$];
  int          wrCycA[$];
  logic [31:0] wrAddrB[$];
  logic [31:0] wrDataB[$];
  logic        cpuSeen;
  int          cpuRise;
  logic        readyDropped;

  typedef struct {
    int          nbytes;
    logic [7:0]  bytes [12];
    int          gapMax;
    int          expWrites;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        immDone;
    logic        immCpu;
    logic        immErr;
    logic        immWe;
    logic        finDone;
    logic        finErr;
    logic        finCpu;
    logic        checkSpacing;
  } vec_t;

  vec_t vecs[4];

  imem_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (readyA),
    .mem_we    (weA),
    .mem_addr  (addrA),
    .mem_wdata (wdataA),
    .cpu_rst_n (cpuA),
    .done      (doneA),
    .error     (errA)
  );

  imem_loader #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0000_1000)) dutB (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (readyB),
    .mem_we    (weB),
    .mem_addr  (addrB),
    .mem_wdata (wdataB),
    .cpu_rst_n (cpuB),
    .done      (doneB),
    .error     (errB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  always @(negedge clk) begin
    if (weA) begin
      wrAddrA.push_back(addrA);
      wrDataA.push_back(wdataA);
      wrCycA.push_back(cycle);
    end
    if (weB) begin
      wrAddrB.push_back(addrB);
      wrDataB.push_back(wdataB);
    end
    if (cpuA && !cpuSeen) begin
      cpuSeen = 1'b1;
      cpuRise = cycle;
    end
    if (rst_n && !readyA && !doneA && !errA) readyDropped = 1'b1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic clearMonitors();
    wrAddrA.delete();
    wrDataA.delete();
    wrCycA.delete();
    wrAddrB.delete();
    wrDataB.delete();
    cpuSeen      = 1'b0;
    cpuRise      = -1;
    readyDropped = 1'b0;
  endtask

  task automatic pulseReset();
    rx_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clearMonitors();
  endtask

  // Called at 1 time unit after a rising edge; returns the same way after the accepting edge.
  task automatic applyStimulus(input logic [7:0] b, input int gapMax);
    int g;
    int waitCnt;
    if (gapMax > 0) begin
      g = $urandom_range(0, gapMax);
      rx_valid = 1'b0;
      repeat (g) begin
        @(posedge clk);
        #1;
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    waitCnt  = 0;
    while (!readyA && waitCnt < 20) begin
      @(posedge clk);
      #1;
      waitCnt++;
    end
    if (!readyA) begin
      checkOutput("byte_accept_timeout", 32'(readyA), 32'd1);
      rx_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    vecs[0] = '{nbytes: 12,
                bytes: '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE},
                gapMax: 0, expWrites: 2, d0: 32'h1234_5678, d1: 32'hDEAD_BEEF,
                immDone: 1, immCpu: 0, immErr: 0, immWe: 1,
                finDone: 1, finErr: 0, finCpu: 1, checkSpacing: 1};
    vecs[1] = vecs[0];
    vecs[1].gapMax       = 5;
    vecs[1].checkSpacing = 0;
    vecs[2] = '{nbytes: 4,
                bytes: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                gapMax: 0, expWrites: 0, d0: 32'h0, d1: 32'h0,
                immDone: 1, immCpu: 1, immErr: 0, immWe: 0,
                finDone: 1, finErr: 0, finCpu: 1, checkSpacing: 0};
    vecs[3] = '{nbytes: 4,
                bytes: '{8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                gapMax: 0, expWrites: 0, d0: 32'h0, d1: 32'h0,
                immDone: 0, immCpu: 0, immErr: 1, immWe: 0,
                finDone: 0, finErr: 1, finCpu: 0, checkSpacing: 0};

    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rst_n    = 1'b0;
    clearMonitors();
    #1;
    checkOutput("async_reset_cpu", 32'(cpuA), 32'd0);
    @(posedge clk);
    #1;
    pulseReset();

    checkOutput("reset_ready", 32'(readyA), 32'd1);
    checkOutput("reset_we", 32'(weA), 32'd0);
    checkOutput("reset_addr", addrA, 32'h0);
    checkOutput("reset_addr_base", addrB, 32'h0000_1000);
    checkOutput("reset_wdata", wdataA, 32'h0);
    checkOutput("reset_cpu", 32'(cpuA), 32'd0);
    checkOutput("reset_done", 32'(doneA), 32'd0);
    checkOutput("reset_error", 32'(errA), 32'd0);

    for (int v = 0; v < 4; v++) begin
      pulseReset();
      for (int i = 0; i < vecs[v].nbytes; i++) applyStimulus(vecs[v].bytes[i], vecs[v].gapMax);
      checkOutput($sformatf("v%0d_imm_done", v), 32'(doneA), 32'(vecs[v].immDone));
      checkOutput($sformatf("v%0d_imm_cpu", v), 32'(cpuA), 32'(vecs[v].immCpu));
      checkOutput($sformatf("v%0d_imm_err", v), 32'(errA), 32'(vecs[v].immErr));
      checkOutput($sformatf("v%0d_imm_we", v), 32'(weA), 32'(vecs[v].immWe));
      rx_valid = 1'b1;
      rx_data  = 8'h5A;
      repeat (4) begin
        @(posedge clk);
        #1;
      end
      rx_valid = 1'b0;
      repeat (3) begin
        @(posedge clk);
        #1;
      end
      checkOutput($sformatf("v%0d_write_count", v), 32'(wrAddrA.size()), 32'(vecs[v].expWrites));
      checkOutput($sformatf("v%0d_write_count_base", v), 32'(wrAddrB.size()), 32'(vecs[v].expWrites));
      for (int w = 0; w < vecs[v].expWrites; w++) begin
        if (w < wrAddrA.size() && w < wrAddrB.size()) begin
          checkOutput($sformatf("v%0d_w%0d_addr", v, w), wrAddrA[w], 32'(4 * w));
          checkOutput($sformatf("v%0d_w%0d_data", v, w), wrDataA[w], (w == 0) ? vecs[v].d0 : vecs[v].d1);
          checkOutput($sformatf("v%0d_w%0d_addr_base", v, w), wrAddrB[w], 32'h0000_1000 + 32'(4 * w));
          checkOutput($sformatf("v%0d_w%0d_data_base", v, w), wrDataB[w], (w == 0) ? vecs[v].d0 : vecs[v].d1);
        end else begin
          checkOutput($sformatf("v%0d_w%0d_missing", v, w), 32'd0, 32'd1);
        end
      end
      if (vecs[v].checkSpacing && wrCycA.size() == 2)
        checkOutput($sformatf("v%0d_we_spacing", v), 32'(wrCycA[1] - wrCycA[0]), 32'd4);
      if (vecs[v].expWrites > 0 && wrCycA.size() > 0)
        checkOutput($sformatf("v%0d_cpu_rise", v), 32'(cpuRise), 32'(wrCycA[wrCycA.size() - 1] + 1));
      checkOutput($sformatf("v%0d_fin_done", v), 32'(doneA), 32'(vecs[v].finDone));
      checkOutput($sformatf("v%0d_fin_err", v), 32'(errA), 32'(vecs[v].finErr));
      checkOutput($sformatf("v%0d_fin_cpu", v), 32'(cpuA), 32'(vecs[v].finCpu));
      checkOutput($sformatf("v%0d_fin_ready", v), 32'(readyA), 32'd0);
      checkOutput($sformatf("v%0d_ready_no_drop", v), 32'(readyDropped), 32'd0);
    end

    // Reset in the middle of a three-word load, then reload a one-word image.
    pulseReset();
    applyStimulus(8'h03, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h11, 0);
    applyStimulus(8'h22, 0);
    applyStimulus(8'h33, 0);
    applyStimulus(8'h44, 0);
    applyStimulus(8'h55, 0);
    applyStimulus(8'h66, 0);
    rx_valid = 1'b0;
    checkOutput("midload_first_write", 32'(wrAddrA.size()), 32'd1);
    checkOutput("midload_wdata_before", wdataA, 32'h4433_2211);
    rst_n = 1'b0;
    #2;
    checkOutput("midload_rst_ready", 32'(readyA), 32'd1);
    checkOutput("midload_rst_we", 32'(weA), 32'd0);
    checkOutput("midload_rst_addr", addrA, 32'h0);
    checkOutput("midload_rst_wdata", wdataA, 32'h0);
    checkOutput("midload_rst_cpu", 32'(cpuA), 32'd0);
    checkOutput("midload_rst_done", 32'(doneA), 32'd0);
    checkOutput("midload_rst_error", 32'(errA), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clearMonitors();
    applyStimulus(8'h01, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'hAA, 0);
    applyStimulus(8'hBB, 0);
    applyStimulus(8'hCC, 0);
    applyStimulus(8'hDD, 0);
    rx_valid = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    checkOutput("reload_write_count", 32'(wrAddrA.size()), 32'd1);
    if (wrAddrA.size() > 0) begin
      checkOutput("reload_addr", wrAddrA[0], 32'h0);
      checkOutput("reload_data", wrDataA[0], 32'hDDCC_BBAA);
    end else begin
      checkOutput("reload_missing", 32'd0, 32'd1);
    end
    checkOutput("reload_done", 32'(doneA), 32'd1);
    checkOutput("reload_cpu", 32'(cpuA), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
